// File: rtl/jk_pkg.sv
// Shared definitions for the multi-mode flip-flop bank: mode encodings and
// the per-bit next-state function used by every cell.
package jk_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    // Result of one bit's next-state evaluation.
    typedef struct packed {
        logic nxt;  // next value of the bit
        logic ill;  // SR mode with S=R=1 (bit holds)
    } jk_result_t;

    // Next state of one flip-flop bit for the given mode.
    // j carries J / D / T / S, k carries K / R.
    function automatic jk_result_t jk_next(
        input logic [1:0] mode,
        input logic       j,
        input logic       k,
        input logic       q
    );
        jk_result_t res;
        res.nxt = q;
        res.ill = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b00:   res.nxt = q;
                    2'b01:   res.nxt = 1'b0;
                    2'b10:   res.nxt = 1'b1;
                    default: res.nxt = ~q;
                endcase
            end
            MODE_D: res.nxt = j;
            MODE_T: res.nxt = j ? ~q : q;
            default: begin
                case ({j, k})
                    2'b00:   res.nxt = q;
                    2'b01:   res.nxt = 1'b0;
                    2'b10:   res.nxt = 1'b1;
                    default: begin
                        // Illegal combination: keep the bit, flag it.
                        res.nxt = q;
                        res.ill = 1'b1;
                    end
                endcase
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One-bit multi-mode flip-flop (JK / D / T / SR) with synchronous reset and
// clock enable. Reports whether the bit is about to change and whether the
// current SR inputs are illegal, both qualified by en.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    output logic       q,
    output logic       qbar,
    output logic       chg,
    output logic       ill
);

    logic       q_reg;
    logic       qbar_reg;
    jk_result_t res_next;

    // Next-state evaluation from the current registered bit.
    always_comb begin
        res_next = jk_next(mode, j, k, q_reg);
    end

    // State register; qbar is held in its own flop so it never glitches
    // against q and always carries the complement, including after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg    <= RESET_BIT;
            qbar_reg <= ~RESET_BIT;
        end else if (en) begin
            q_reg    <= res_next.nxt;
            qbar_reg <= ~res_next.nxt;
        end
    end

    assign q    = q_reg;
    assign qbar = qbar_reg;
    assign chg  = en & (res_next.nxt != q_reg);
    assign ill  = en & res_next.ill;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of multi-mode flip-flops sharing one runtime mode select.
// Owns the sticky illegal-SR flag and the saturating change-event counter.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] chg_vec;
    logic [WIDTH-1:0] ill_vec;
    logic             chg_any;
    logic             ill_any;
    logic             sr_err_reg;
    logic [CNT_W-1:0] chg_cnt_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell #(
                .RESET_BIT (RESET_VAL[gi])
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .mode (mode),
                .j    (j[gi]),
                .k    (k[gi]),
                .q    (q[gi]),
                .qbar (qbar[gi]),
                .chg  (chg_vec[gi]),
                .ill  (ill_vec[gi])
            );
        end
    endgenerate

    // Any bit changing counts as one event; any illegal bit raises the flag.
    always_comb begin
        chg_any = |chg_vec;
        ill_any = |ill_vec;
    end

    // Sticky error flag: a new error beats a simultaneous clear; the clear
    // is honoured even while the bank is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_err_reg <= 1'b0;
        end else if (ill_any) begin
            sr_err_reg <= 1'b1;
        end else if (err_clr) begin
            sr_err_reg <= 1'b0;
        end
    end

    // Saturating count of enabled cycles where q changed (chg is en-qualified).
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_cnt_reg <= '0;
        end else if (chg_any && (chg_cnt_reg != CNT_MAX)) begin
            chg_cnt_reg <= chg_cnt_reg + 1'b1;
        end
    end

    assign sr_err  = sr_err_reg;
    assign chg_cnt = chg_cnt_reg;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=8, RESET_VAL=A5, CNT_W=4).
// Stimulus pushes the hand-computed response for each edge; a monitor pops
// and compares one entry shortly after every rising edge.
module tb_jk_reg_bank;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] j = '0;
    logic [WIDTH-1:0] k = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             sr_err;
    logic [CNT_W-1:0] chg_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             err;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    exp_t sb[$];

    jk_reg_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'hA5),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .err_clr (err_clr),
        .q       (q),
        .qbar    (qbar),
        .sr_err  (sr_err),
        .chg_cnt (chg_cnt)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of inputs and queue the expected result.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] jj, input logic [7:0] kk, input logic ec,
                        input logic [7:0] eq, input logic ee, input logic [3:0] ecnt,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; j = jj; k = kk; err_clr = ec;
        x.q = eq; x.err = ee; x.cnt = ecnt; x.name = nm;
        sb.push_back(x);
        @(posedge clk);
    endtask

    // Monitor: compare every queued expectation just after its edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (q !== x.q) begin
                    failures++;
                    $display("FAIL %s q: got %h expected %h", x.name, q, x.q);
                end
                checks++;
                if (qbar !== ~x.q) begin
                    failures++;
                    $display("FAIL %s qbar: got %h expected %h", x.name, qbar, ~x.q);
                end
                checks++;
                if (sr_err !== x.err) begin
                    failures++;
                    $display("FAIL %s sr_err: got %b expected %b", x.name, sr_err, x.err);
                end
                checks++;
                if (chg_cnt !== x.cnt) begin
                    failures++;
                    $display("FAIL %s chg_cnt: got %h expected %h", x.name, chg_cnt, x.cnt);
                end
                $display("txn %-10s q=%h qbar=%h sr_err=%b chg_cnt=%h", x.name, q, qbar, sr_err, chg_cnt);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rj;
        logic [7:0] rk;
        logic [1:0] rm;
        logic [7:0] eq;
        int         ecnt;

        // Reset, then enable low with arbitrary inputs: everything holds.
        step(1, 0, 2'b00, 8'h00, 8'h00, 0, 8'hA5, 0, 4'h0, "reset");
        for (int i = 0; i < 5; i++) begin
            rj = 8'($urandom); rk = 8'($urandom); rm = 2'($urandom);
            step(0, 0, rm, rj, rk, 0, 8'hA5, 0, 4'h0, "hold_en0");
        end

        // JK mode.
        step(0, 1, 2'b00, 8'hF0, 8'h0F, 0, 8'hF0, 0, 4'h1, "jk_setclr");
        step(0, 1, 2'b00, 8'hFF, 8'hFF, 0, 8'h0F, 0, 4'h2, "jk_toggle");
        step(0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h0F, 0, 4'h2, "jk_hold");

        // D and T modes.
        step(0, 1, 2'b01, 8'h3C, 8'hFF, 0, 8'h3C, 0, 4'h3, "d_load");
        step(0, 1, 2'b10, 8'hFF, 8'h00, 0, 8'hC3, 0, 4'h4, "t_toggle");
        step(0, 1, 2'b10, 8'h00, 8'hFF, 0, 8'hC3, 0, 4'h4, "t_hold");
        step(0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h00, 0, 4'h5, "d_zero");

        // SR mode with an illegal bit; set beats clear.
        step(0, 1, 2'b11, 8'h81, 8'h01, 0, 8'h80, 1, 4'h6, "sr_illegal");
        step(0, 1, 2'b11, 8'h81, 8'h01, 1, 8'h80, 1, 4'h6, "sr_setwins");
        step(0, 1, 2'b11, 8'h00, 8'h00, 1, 8'h80, 0, 4'h6, "sr_clear");
        step(0, 1, 2'b11, 8'h01, 8'h01, 0, 8'h80, 1, 4'h6, "sr_again");
        step(0, 0, 2'b11, 8'hFF, 8'hFF, 1, 8'h80, 0, 4'h6, "clr_en0");
        step(0, 1, 2'b11, 8'h01, 8'h00, 0, 8'h81, 0, 4'h7, "sr_set");
        step(0, 1, 2'b11, 8'h00, 8'h01, 0, 8'h80, 0, 4'h8, "sr_reset");

        // Saturation: toggle bit 0 for 20 cycles from q=80, cnt=8.
        eq = 8'h80;
        ecnt = 8;
        for (int i = 1; i <= 20; i++) begin
            eq = eq ^ 8'h01;
            ecnt = (ecnt < 15) ? ecnt + 1 : 15;
            step(0, 1, 2'b10, 8'h01, 8'h00, 0, eq, 0, 4'(ecnt), "t_sat");
        end
        step(1, 1, 2'b10, 8'h01, 8'h00, 0, 8'hA5, 0, 4'h0, "rst_sat");

        // Reset wins over an enabled D load on the same edge.
        step(0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h00, 0, 4'h1, "d_pre");
        step(1, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hA5, 0, 4'h0, "rst_mid");
        step(0, 1, 2'b11, 8'hFF, 8'hFF, 0, 8'hA5, 1, 4'h0, "sr_allill");
        step(1, 1, 2'b11, 8'hFF, 8'hFF, 0, 8'hA5, 0, 4'h0, "rst_err");

        @(negedge clk);
        rst = 0; en = 0;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised multi-mode flip-flop bank: WIDTH independent bits, each updated on `clk` as a JK, D, T or SR flip-flop according to a shared runtime mode select. It generalises the team's single-bit JK flip-flop and JK-to-D conversion. It adds synchronous reset, clock enable, illegal-SR detection and a saturating change-event counter. It sits wherever the design needs a configurable register of flip-flops, such as control/status latches or toggle masks.

## Interface
- `WIDTH`, default 8: number of flip-flop bits, at least 1.
- `RESET_VAL`, default 0 (WIDTH bits): value loaded into `q` on reset.
- `CNT_W`, default 8: width of the change counter, at least 1.

- `clk`  in  1  rising-edge clock; sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  clock enable; low means every register holds.
- `mode`  in  2  00 JK, 01 D, 10 T, 11 SR.
- `j`  in  WIDTH  per-bit J / D / T / S input, depending on mode.
- `k`  in  WIDTH  per-bit K / R input; ignored in D and T modes.
- `err_clr`  in  1  clears `sr_err`.
- `q`  out  WIDTH  registered state.
- `qbar`  out  WIDTH  registered complement; always equals ~`q`.
- `sr_err`  out  1  sticky flag for an illegal SR input.
- `chg_cnt`  out  CNT_W  saturating count of enabled cycles in which `q` changed.

## Operation
- Reset (`rst`=1 at a rising edge) has top priority over all other inputs. It sets:
  - `q`=RESET_VAL and `qbar`=~RESET_VAL
  - `sr_err`=0
  - `chg_cnt`=0
- When `en`=0 and `rst`=0, `q`, `qbar`, `sr_err` and `chg_cnt` hold. `err_clr` is still honoured.
- Per-bit next state with `en`=1:
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - D: q←j.
  - T: j=1 toggles, j=0 holds.
  - SR: S=1,R=0 sets; S=0,R=1 clears; 00 holds; 11 is illegal, so the bit holds and an error is raised.
- `sr_err` is set when `en`=1, `mode`=11 and any bit has j&k=1. It stays set until `err_clr` or `rst`.
- If a new error and `err_clr` occur in the same cycle, the set wins and `sr_err` stays 1.
- `chg_cnt` increments by 1 when `en`=1 and next `q` differs from current `q` in any bit. The increment is 1 regardless of how many bits changed. It stops at 2^CNT_W−1 and never wraps.
- Changing `mode` between cycles needs no settling; each edge uses the mode present at that edge.

## Timing
- All outputs are registered. Inputs sampled at edge N appear on `q`/`qbar` after edge N, so latency is 1 cycle.
- `sr_err` and `chg_cnt` update on the same edge as the `q` update that caused them.
- `qbar` is never equal to `q` in any bit on any cycle, including the cycle after reset.
- Reset asserted mid-sequence takes effect on that edge; no partial update of any bit survives.
- There is no combinational path from any input to any output.

## Structure
- Shared package `jk_pkg`:
  - mode localparams `MODE_JK`, `MODE_D`, `MODE_T`, `MODE_SR` (2 bits);
  - function `jk_next(mode, j, k, q)` returning the next bit and an illegal flag.
- Sub-module `jk_cell`: a one-bit multi-mode flip-flop with `clk`, `rst`, `en`, `mode`, `j`, `k` and a per-bit reset value.
  - It outputs `q`, `qbar`, `chg` (bit will change) and `ill` (SR 11).
  - It is instantiated WIDTH times in a generate loop.
- The top level ORs the `chg` and `ill` vectors and owns the `sr_err` and `chg_cnt` registers.

## Test plan
All scenarios use WIDTH=8, RESET_VAL=8'hA5 and CNT_W=4 unless stated.
- Reset: `rst`=1 for one edge → `q`=A5, `qbar`=5A, `sr_err`=0, `chg_cnt`=0. Then `rst`=0 with `en`=0 and random j/k for 5 cycles → all outputs unchanged.
- JK mode, from `q`=A5:
  - j=F0, k=0F → `q`=F0.
  - Then j=k=FF → `q`=0F.
  - Then j=k=00 → `q`=0F.
  - `chg_cnt`=2 at the end.
- D and T modes:
  - D with j=3C → `q`=3C.
  - T with j=FF → `q`=C3.
  - T with j=00 → `q`=C3.
  - `chg_cnt` increments only on the changing cycles.
- SR illegal: from `q`=00 with j=81, k=01 → `q`=80 and `sr_err`=1.
  - `err_clr`=1 with the same j/k next cycle → `sr_err` stays 1 (set wins).
  - `err_clr`=1 with j=k=00 → `sr_err`=0.
- Saturation: T mode, j=01 for 20 enabled cycles → `chg_cnt` reaches F and stays F. Then `rst`=1 → `chg_cnt`=0 and `q`=A5.
- Reset mid-operation: `rst`=1 on the same edge as D mode with j=FF and `en`=1 → `q`=A5, not FF, and `chg_cnt`=0.
